instr_mem: RTL and testbench

INSTR_MEM -- requirements
Module: instr_mem

---
 rtl/instr_mem.sv | 89 ++++++++
 tb/tb_instr_mem.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/instr_mem.sv
// instr_mem: word-addressed instruction memory behind a valid/ready fetch bus.
//   Ports:
//     clk, rst_n          clock; asynchronous active-low reset
//     if_req_valid_i      fetch request valid
//     if_req_ready_o      request can be accepted this cycle
//     if_req_pc_i         byte address of the requested instruction
//     if_resp_valid_o     response valid
//     if_resp_ready_i     fetch unit takes the response
//     if_resp_err_o       misaligned or out-of-range request
//     if_resp_instr_o     instruction word (0 on error)
//     wr_en_i             memory write strobe, independent of the fetch FSM
//     wr_addr_i           byte address of the write (must be word aligned)
//     wr_data_i           write data
module instr_mem #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 1024,
    parameter int RESP_LAT    = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   if_req_valid_i,
    output logic                   if_req_ready_o,
    input  logic [PC_WIDTH-1:0]    if_req_pc_i,
    output logic                   if_resp_valid_o,
    input  logic                   if_resp_ready_i,
    output logic                   if_resp_err_o,
    output logic [INSTR_WIDTH-1:0] if_resp_instr_o,
    input  logic                   wr_en_i,
    input  logic [PC_WIDTH-1:0]    wr_addr_i,
    input  logic [INSTR_WIDTH-1:0] wr_data_i
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
    state_e                 state_q, state_d;
    logic [2:0]             cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [INSTR_WIDTH-1:0] mem [DEPTH];
    logic [PC_WIDTH-1:0]    req_hi, wr_hi;
    logic                   req_err, wr_ok, accept;
    // Any address bit above the word index marks the access out of range.
    assign req_hi  = if_req_pc_i >> (AW + 2);
    assign wr_hi   = wr_addr_i >> (AW + 2);
    assign req_err = (if_req_pc_i[1:0] != 2'b00) || (req_hi != '0);
    assign wr_ok   = wr_en_i && (wr_addr_i[1:0] == 2'b00) && (wr_hi == '0);
    // Gated by rst_n so the bus sees not-ready while reset is held.
    assign if_req_ready_o  = rst_n && (state_q == IDLE || (state_q == RESP && if_resp_ready_i));
    assign accept          = if_req_valid_i && if_req_ready_o;
    assign if_resp_valid_o = state_q == RESP;
    assign if_resp_err_o   = err_q;
    assign if_resp_instr_o = instr_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        instr_d = instr_q;
        if (state_q == BUSY) begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) state_d = RESP;
        end
        if (state_q == RESP && if_resp_ready_i) state_d = IDLE;
        // The word is captured at accept, so later writes cannot disturb the
        // pending response and a same-cycle write yields the old contents.
        if (accept) begin
            state_d = (RESP_LAT == 1) ? RESP : BUSY;
            cnt_d   = 3'(RESP_LAT - 1);
            err_d   = req_err;
            instr_d = req_err ? '0 : mem[if_req_pc_i[AW+1:2]];
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            instr_q <= instr_d;
        end
    end
    // Array contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_addr_i[AW+1:2]] <= wr_data_i;
    end
endmodule

// File: tb/tb_instr_mem.sv
// tb_instr_mem: self-checking bench for instr_mem at RESP_LAT 1, 3 and 4.
module tb_instr_mem;
    localparam int D = 64;
    logic        clk, rst_n;
    logic        req_valid [3];
    logic        req_ready [3];
    logic [31:0] req_pc [3];
    logic        resp_valid [3];
    logic        resp_ready [3];
    logic        resp_err [3];
    logic [31:0] resp_instr [3];
    logic        wr_en;
    logic [31:0] wr_addr, wr_data;
    logic [31:0] mdl [D];
    int checks = 0;
    int errors = 0;

    function automatic int lat(input int k);
        return k == 0 ? 1 : (k == 1 ? 3 : 4);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        instr_mem #(.DEPTH(D), .RESP_LAT(g == 0 ? 1 : (g == 1 ? 3 : 4))) u_dut (
            .clk(clk), .rst_n(rst_n),
            .if_req_valid_i(req_valid[g]), .if_req_ready_o(req_ready[g]),
            .if_req_pc_i(req_pc[g]), .if_resp_valid_o(resp_valid[g]),
            .if_resp_ready_i(resp_ready[g]), .if_resp_err_o(resp_err[g]),
            .if_resp_instr_o(resp_instr[g]), .wr_en_i(wr_en),
            .wr_addr_i(wr_addr), .wr_data_i(wr_data)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_err(input logic [31:0] pc);
        return (pc % 4 != 0) || (pc / 4 >= D);
    endfunction

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
        if (a % 4 == 0 && a / 4 < D) mdl[a / 4] = d;
    endtask

    task automatic fetch(input int k, input logic [31:0] pc, input int hold);
        logic e_err, rs;
        logic [31:0] e_instr;
        int n;
        req_valid[k] = 1'b1; req_pc[k] = pc; resp_ready[k] = 1'b0; n = 0;
        while (!req_ready[k] && n < 20) begin @(posedge clk); #1; n++; end
        chk($sformatf("accept_wait%0d", k), n < 20, 1);
        e_err = exp_err(pc);
        e_instr = 0;
        if (!e_err) e_instr = mdl[pc / 4];
        @(posedge clk); #1;
        req_valid[k] = 1'b0; req_pc[k] = $urandom; n = 1; rs = 1'b0;
        while (!resp_valid[k] && n < 20) begin
            rs |= req_ready[k];
            @(posedge clk); #1; n++;
        end
        chk($sformatf("latency%0d", k), n, lat(k));
        chk($sformatf("busy_ready%0d", k), rs, 0);
        chk($sformatf("instr%0d", k), resp_instr[k], e_instr);
        chk($sformatf("err%0d", k), resp_err[k], e_err);
        for (int i = 0; i < hold; i++) begin
            wr(pc & ~32'h3, $urandom);
            chk($sformatf("hold_valid%0d", k), resp_valid[k], 1);
            chk($sformatf("hold_instr%0d", k), resp_instr[k], e_instr);
            chk($sformatf("hold_err%0d", k), resp_err[k], e_err);
            chk($sformatf("hold_ready%0d", k), req_ready[k], 0);
        end
        resp_ready[k] = 1'b1; #1;
        chk($sformatf("resp_req_ready%0d", k), req_ready[k], 1);
        @(posedge clk); #1;
        resp_ready[k] = 1'b0;
        chk($sformatf("idle%0d", k), resp_valid[k], 0);
    endtask

    initial begin
        logic [31:0] pc, old, nw;
        for (int k = 0; k < 3; k++) begin
            req_valid[k] = 1'b0; req_pc[k] = 0; resp_ready[k] = 1'b0;
        end
        wr_en = 1'b0; wr_addr = 0; wr_data = 0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_valid%0d", k), resp_valid[k], 0);
            chk($sformatf("rst_err%0d", k), resp_err[k], 0);
            chk($sformatf("rst_instr%0d", k), resp_instr[k], 0);
            chk($sformatf("rst_ready%0d", k), req_ready[k], 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; #1;
        for (int k = 0; k < 3; k++) chk($sformatf("post_rst_ready%0d", k), req_ready[k], 1);
        for (int i = 0; i < D; i++) wr(4 * i, $urandom);
        wr(32'h8, 32'h0000_0013);
        fetch(0, 32'h8, 0);
        fetch(1, 32'h0, 0);
        fetch(0, 32'h14, 4);
        fetch(2, 32'h20, 4);
        for (int k = 0; k < 3; k++) begin
            fetch(k, 32'h6, 0);
            fetch(k, 4 * D, 0);
        end
        wr(4 * D + 8, 32'hdead_beef);
        wr(32'h9, 32'hcafe_f00d);
        fetch(0, 32'h8, 0);
        resp_ready[0] = 1'b1; req_valid[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_pc[0] = 4 * i;
            @(posedge clk); #1;
            chk($sformatf("stream_valid%0d", i), resp_valid[0], 1);
            chk($sformatf("stream_instr%0d", i), resp_instr[0], mdl[i]);
        end
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        resp_ready[0] = 1'b0;
        chk("stream_idle", resp_valid[0], 0);
        old = mdl[4]; nw = ~old;
        req_valid[0] = 1'b1; req_pc[0] = 32'h10;
        wr_en = 1'b1; wr_addr = 32'h10; wr_data = nw;
        @(posedge clk); #1;
        wr_en = 1'b0; req_valid[0] = 1'b0; mdl[4] = nw;
        chk("rbw_valid", resp_valid[0], 1);
        chk("rbw_instr", resp_instr[0], old);
        resp_ready[0] = 1'b1;
        @(posedge clk); #1;
        resp_ready[0] = 1'b0;
        fetch(0, 32'h10, 0);
        req_valid[2] = 1'b1; req_pc[2] = 32'h4;
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        chk("midrst_valid", resp_valid[2], 0);
        chk("midrst_ready", req_ready[2], 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("midrst_quiet%0d", i), resp_valid[2], 0);
            @(posedge clk); #1;
        end
        fetch(2, 32'h4, 1);
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 2))
                0: pc = 4 * $urandom_range(0, D - 1);
                1: pc = 4 * $urandom_range(0, D - 1) + $urandom_range(1, 3);
                default: pc = 4 * D + 4 * $urandom_range(0, 1000);
            endcase
            fetch($urandom_range(0, 2), pc, $urandom_range(0, 3));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
